// File: rtl/btn_evt_pkg.sv
// Shared types for the button event scheduler: event type encoding and the
// packed event record carried through the FIFO.
package btn_evt_pkg;

    localparam int unsigned EVT_W = 2;
    // Wide enough for the largest supported button count (8).
    localparam int unsigned BTN_IDX_W = 3;

    typedef enum logic [EVT_W-1:0] {
        EvtPress   = 2'd0,
        EvtLong    = 2'd1,
        EvtRepeat  = 2'd2,
        EvtRelease = 2'd3
    } evt_type_t;

    typedef struct packed {
        logic [BTN_IDX_W-1:0] btn;
        evt_type_t            typ;
    } evt_t;

endpackage

// File: rtl/button_event_scheduler_if.sv
// Valid/ready event port between the scheduler (master) and its consumer.
interface button_event_scheduler_if
    import btn_evt_pkg::*;
#(
    parameter int unsigned N_BTN = 4
);
    localparam int unsigned IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_btn;
    logic [EVT_W-1:0] evt_type;

    modport master (output evt_valid, output evt_btn, output evt_type, input evt_ready);
    modport slave  (input evt_valid, input evt_btn, input evt_type, output evt_ready);

endinterface

// File: rtl/btn_evt_fifo.sv
// Small synchronous FIFO of event records. Pushes are refused while full,
// even when a pop happens in the same cycle.
module btn_evt_fifo
    import btn_evt_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  evt_t wdata,
    input  logic pop,
    output evt_t rdata,
    output logic full,
    output logic empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    evt_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is reset so the head reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/button_event_scheduler.sv
// Turns debounced button levels into an ordered stream of PRESS/LONG/REPEAT/
// RELEASE events: per-button trackers feed one-deep pending slots, a
// round-robin arbiter moves one slot per cycle into the output FIFO.
module button_event_scheduler
    import btn_evt_pkg::*;
#(
    parameter int unsigned N_BTN    = 4,
    parameter int unsigned LONG_CYC = 12_000_000,
    parameter int unsigned REP_CYC  = 2_400_000,
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_BTN-1:0]        btn_state,
    button_event_scheduler_if.master evt,
    output logic                    ovf,
    input  logic                    ovf_clr
);
    localparam int unsigned IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic [N_BTN-1:0] pend_vld;
    evt_type_t        pend_type [N_BTN];
    logic [N_BTN-1:0] grant;
    logic [N_BTN-1:0] drop;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    evt_t             fifo_wdata;
    evt_t             fifo_rdata;
    logic             unused_rdata;

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
        logic             prev_q;
        logic             rep_q;
        logic [CNT_W-1:0] cnt_q;
        logic             pend_q;
        evt_type_t        ptype_q;
        logic [CNT_W-1:0] cnt_inc;
        logic [CNT_W-1:0] cnt_d;
        logic             rep_d;
        logic             gen;
        evt_type_t        gen_type;
        logic             slot_busy;

        assign cnt_inc   = cnt_q + 1'b1;
        // Slot counts as free if it is being granted this very cycle.
        assign slot_busy = pend_q & ~grant[i];
        assign drop[i]   = gen & slot_busy;
        assign pend_vld[i]  = pend_q;
        assign pend_type[i] = ptype_q;

        // Edge/hold tracker: decides the event (if any) and next counter state.
        always_comb begin
            gen      = 1'b0;
            gen_type = EvtPress;
            cnt_d    = cnt_q;
            rep_d    = rep_q;
            if (btn_state[i] && !prev_q) begin
                gen   = 1'b1;
                cnt_d = CNT_W'(1);
            end else if (btn_state[i] && prev_q) begin
                if (!rep_q && (cnt_inc == CNT_W'(LONG_CYC))) begin
                    gen      = 1'b1;
                    gen_type = EvtLong;
                    rep_d    = 1'b1;
                    cnt_d    = '0;
                end else if (rep_q && (cnt_inc == CNT_W'(REP_CYC))) begin
                    gen      = 1'b1;
                    gen_type = EvtRepeat;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else if (!btn_state[i] && prev_q) begin
                gen      = 1'b1;
                gen_type = EvtRelease;
                cnt_d    = '0;
                rep_d    = 1'b0;
            end
        end

        // Tracker state and pending slot; a new event into a busy slot is lost.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_q  <= 1'b0;
                rep_q   <= 1'b0;
                cnt_q   <= '0;
                pend_q  <= 1'b0;
                ptype_q <= EvtPress;
            end else begin
                prev_q <= btn_state[i];
                rep_q  <= rep_d;
                cnt_q  <= cnt_d;
                if (gen && !slot_busy) begin
                    pend_q  <= 1'b1;
                    ptype_q <= gen_type;
                end else if (grant[i]) begin
                    pend_q <= 1'b0;
                end
            end
        end
    end

    // Round-robin pick: scan from the highest offset down so the lowest
    // offset from the pointer wins.
    always_comb begin
        logic [IDX_W:0] sum;
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int off = int'(N_BTN) - 1; off >= 0; off--) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(N_BTN)) begin
                sum = sum - (IDX_W+1)'(N_BTN);
            end
            if (pend_vld[sum[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = sum[IDX_W-1:0];
            end
        end
    end

    assign push = grant_any & ~fifo_full;

    // One-hot grant, only when the push actually happens.
    always_comb begin
        grant = '0;
        if (push) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign fifo_wdata = '{btn: BTN_IDX_W'(grant_idx), typ: pend_type[grant_idx]};

    // Pointer moves past the winner; sticky overflow with set over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr <= (grant_idx == IDX_W'(N_BTN - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (|drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    btn_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (evt.evt_valid & evt.evt_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt.evt_valid = ~fifo_empty;
    assign evt.evt_btn   = fifo_rdata.btn[IDX_W-1:0];
    assign evt.evt_type  = fifo_rdata.typ;
    assign unused_rdata  = ^fifo_rdata.btn;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench: stimulus pushes expected events into a queue, a monitor
// pops and compares on every accepted transfer.
module tb_button_event_scheduler;
    import btn_evt_pkg::*;

    localparam int unsigned N_BTN    = 4;
    localparam int unsigned LONG_CYC = 10;
    localparam int unsigned REP_CYC  = 4;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned DEPTH    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_BTN-1:0] btn_state;
    logic             ovf;
    logic             ovf_clr;

    button_event_scheduler_if #(.N_BTN(N_BTN)) evt_if ();

    button_event_scheduler #(
        .N_BTN    (N_BTN),
        .LONG_CYC (LONG_CYC),
        .REP_CYC  (REP_CYC),
        .CNT_W    (CNT_W),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_state (btn_state),
        .evt       (evt_if),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] sb_q[$];
    logic [3:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input logic [1:0] btn, input evt_type_t t);
        sb_q.push_back({btn, t});
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            tick(1);
            k++;
        end
        tick(3);
        check({name, "_drained"}, sb_q.size(), 0);
        check({name, "_idle"}, evt_if.evt_valid, 0);
    endtask

    // Scoreboard monitor: every accepted transfer must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got btn %0d type %0d, expected none",
                         evt_if.evt_btn, evt_if.evt_type);
            end else begin
                mon_exp = sb_q.pop_front();
                check("event", {evt_if.evt_btn, evt_if.evt_type}, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic exp_v;
        rst_n            = 1'b0;
        btn_state        = '0;
        ovf_clr          = 1'b0;
        evt_if.evt_ready = 1'b1;
        tick(2);
        check("rst_valid", evt_if.evt_valid, 0);
        check("rst_btn", evt_if.evt_btn, 0);
        check("rst_type", evt_if.evt_type, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick(2);

        // Simultaneous rises with pointer 0: order 0, 1, 3 (and the releases too).
        expect_evt(2'd0, EvtPress);
        expect_evt(2'd1, EvtPress);
        expect_evt(2'd3, EvtPress);
        btn_state = 4'b1011;
        tick(4);
        expect_evt(2'd0, EvtRelease);
        expect_evt(2'd1, EvtRelease);
        expect_evt(2'd3, EvtRelease);
        btn_state = 4'b0000;
        drain("rr");

        // Fill FIFO and all slots with the consumer stalled, then force drops.
        evt_if.evt_ready = 1'b0;
        for (int b = 0; b < 4; b++) expect_evt(2'(b), EvtPress);
        btn_state = 4'b1111;
        tick(6);
        check("full_valid", evt_if.evt_valid, 1);
        check("full_head", {evt_if.evt_btn, evt_if.evt_type}, {2'd0, EvtPress});
        for (int b = 0; b < 4; b++) expect_evt(2'(b), EvtRelease);
        btn_state = 4'b0000;
        tick(2);
        check("ovf_before_drop", ovf, 0);
        btn_state = 4'b0001;
        tick(1);
        check("ovf_after_drop", ovf, 1);
        check("head_stable", {evt_if.evt_btn, evt_if.evt_type}, {2'd0, EvtPress});
        btn_state = 4'b0000;
        tick(1);
        check("ovf_sticky", ovf, 1);
        // Clear coinciding with a drop: set wins.
        btn_state = 4'b0010;
        ovf_clr   = 1'b1;
        tick(1);
        check("ovf_set_beats_clr", ovf, 1);
        btn_state = 4'b0000;
        tick(1);
        check("ovf_set_beats_clr2", ovf, 1);
        tick(1);
        check("ovf_cleared", ovf, 0);
        ovf_clr          = 1'b0;
        evt_if.evt_ready = 1'b1;
        drain("ovf");

        // Short press of button 2 with latency check.
        expect_evt(2'd2, EvtPress);
        btn_state = 4'b0100;
        tick(1);
        check("lat_t_plus1", evt_if.evt_valid, 0);
        tick(1);
        check("lat_t_plus2", evt_if.evt_valid, 1);
        check("lat_head", {evt_if.evt_btn, evt_if.evt_type}, {2'd2, EvtPress});
        tick(1);
        expect_evt(2'd2, EvtRelease);
        btn_state = 4'b0000;
        drain("short");

        // Long hold of button 1: LONG at sample 10, REPEAT at 14 and 18.
        expect_evt(2'd1, EvtPress);
        expect_evt(2'd1, EvtLong);
        expect_evt(2'd1, EvtRepeat);
        expect_evt(2'd1, EvtRepeat);
        expect_evt(2'd1, EvtRelease);
        btn_state = 4'b0010;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            exp_v = (k == 2 || k == 11 || k == 15 || k == 19);
            check($sformatf("hold_valid_s%0d", k), evt_if.evt_valid, exp_v);
        end
        btn_state = 4'b0000;
        drain("hold");

        // Reset mid-hold with a queued event; PRESS must come back afterwards.
        evt_if.evt_ready = 1'b0;
        btn_state        = 4'b0100;
        tick(4);
        check("prereset_valid", evt_if.evt_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", evt_if.evt_valid, 0);
        check("async_rst_btn", evt_if.evt_btn, 0);
        check("async_rst_type", evt_if.evt_type, 0);
        check("async_rst_ovf", ovf, 0);
        sb_q.delete();
        tick(1);
        expect_evt(2'd2, EvtPress);
        rst_n            = 1'b1;
        evt_if.evt_ready = 1'b1;
        tick(3);
        expect_evt(2'd2, EvtRelease);
        btn_state = 4'b0000;
        drain("reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
